serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor: the inverse operation to the team's `serial_adder`. It captures two parallel operands on `load` and processes one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. After N cycles it presents the parallel difference and borrow-out. Verification pairs it with `serial_adder` for round-trip checks, e.g. (a + b) − b = a.

---
 rtl/serial_subtractor.sv | 102 ++++++++++
 tb/tb_serial_subtractor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial N-bit unsigned subtractor, the companion of serial_adder.
// Both operands are captured on a load edge. One bit is processed per clock,
// LSB first, through a single full-subtractor cell whose borrow is kept in a
// flop. N edges after the last load, the parallel difference and borrow-out
// are presented and done is raised.
//
// Ports
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-low reset
//   a      in   N  minuend, sampled on a load edge
//   b      in   N  subtrahend, sampled on a load edge
//   load   in   1  start / restart request
//   diff   out  N  registered (a - b) mod 2^N
//   bout   out  1  registered borrow-out, high iff a < b
//   busy   out  1  high while bits are being processed
//   done   out  1  result valid, held until the next load or reset
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         load,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state_q;
  logic [N-1:0]   sa_q;
  logic [N-1:0]   sb_q;
  logic [N-1:0]   sd_q;
  logic           br_q;
  logic [CW-1:0]  cnt_q;

  logic           diffBit_d;
  logic           borrow_d;
  logic [N-1:0]   sdShift_d;

  // Full-subtractor cell on the current LSBs and the stored borrow. The
  // shifted difference is also the final result on the completion edge.
  assign diffBit_d = sa_q[0] ^ sb_q[0] ^ br_q;
  assign borrow_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign sdShift_d = {diffBit_d, sd_q[N-1:1]};

  // Single-process FSM. load has priority over everything else, so it also
  // wins over the completion edge. In that case the finishing result is
  // dropped and done stays low. diff/bout are only written on completion,
  // which keeps partial results invisible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff    <= '0;
      bout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (load) begin
      state_q <= SHIFT;
      sa_q    <= a;
      sb_q    <= b;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (state_q == SHIFT) begin
      sa_q  <= sa_q >> 1;
      sb_q  <= sb_q >> 1;
      sd_q  <= sdShift_d;
      br_q  <= borrow_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST_BIT) begin
        // The counter is cleared explicitly because N need not be a power of two.
        cnt_q   <= '0;
        diff    <= sdShift_d;
        bout    <= borrow_d;
        done    <= 1'b1;
        busy    <= 1'b0;
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor. It uses one N=4 instance for the
// directed, exhaustive and round-trip scenarios. It uses one N=8 instance for
// random operands. The expected result of each operation is pushed to a queue
// when its load is driven, and popped when done rises.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] a4, b4, diff4;
  logic       load4, bout4, busy4, done4;

  logic [7:0] a8, b8, diff8;
  logic       load8, bout8, busy8, done8;

  exp_t q4[$];
  exp_t q8[$];

  int nChecks = 0;
  int nFails  = 0;

  // Expected diff4 value that the DUT should currently be holding.
  logic [3:0] heldDiff4 = 4'd0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .a(a4), .b(b4), .load(load4),
    .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .load(load8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
  );

  // Drives one load pulse to the N=4 DUT and queues the expected result.
  // The task returns on the falling edge right after the load edge.
  task automatic startOp4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    exp_t e;
    d = a - b;
    e.diff = {4'd0, d};
    e.bout = (a < b);
    @(negedge clk);
    a4 = a; b4 = b; load4 = 1'b1;
    q4.push_back(e);
    @(negedge clk);
    load4 = 1'b0;
  endtask

  task automatic startOp8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    exp_t e;
    d = a - b;
    e.diff = d;
    e.bout = (a < b);
    @(negedge clk);
    a8 = a; b8 = b; load8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    load8 = 1'b0;
  endtask

  // Counts the falling edges until done rises. The wait gives up after 20 edges.
  task automatic waitDone4(output int edges);
    edges = 0;
    while (!done4 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic waitDone8(output int edges);
    edges = 0;
    while (!done8 && edges < 30) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load4 = 1'b0; load8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #20;
    nChecks++;
    if ({diff4, bout4, busy4, done4} !== 7'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs4: got %b, want 0000000", {diff4, bout4, busy4, done4});
    end
    nChecks++;
    if ({diff8, bout8, busy8, done8} !== 11'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs8: got %b, want 0", {diff8, bout8, busy8, done8});
    end
    @(negedge clk);
    reset = 1'b1;
    heldDiff4 = 4'd0;
  endtask

  task automatic test_basic();
    int edges;
    exp_t e;
    startOp4(4'b1010, 4'b0111);
    nChecks++;
    if (busy4 !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL basic_busy_start: got %b, want 1", busy4);
    end
    waitDone4(edges);
    e = q4.pop_front();
    nChecks++;
    if (edges != 4) begin
      nFails++;
      $display("[TB] FAIL basic_latency: got %0d edges, want 4", edges);
    end
    nChecks++;
    if (diff4 !== 4'b0011 || diff4 !== e.diff[3:0]) begin
      nFails++;
      $display("[TB] FAIL basic_diff: got %b, want 0011", diff4);
    end
    nChecks++;
    if (bout4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL basic_flags: got bout=%b busy=%b done=%b, want 0 0 1", bout4, busy4, done4);
    end
    heldDiff4 = e.diff[3:0];
  endtask

  task automatic test_reset_midop();
    startOp4(4'b1111, 4'b0001);
    void'(q4.pop_back());
    @(negedge clk);
    reset = 1'b0;
    #1;
    nChecks++;
    if ({diff4, bout4, busy4, done4} !== 7'd0) begin
      nFails++;
      $display("[TB] FAIL midop_reset_async: got %b, want 0000000", {diff4, bout4, busy4, done4});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    heldDiff4 = 4'd0;
    repeat (6) @(negedge clk);
    nChecks++;
    if ({diff4, bout4, busy4, done4} !== 7'd0) begin
      nFails++;
      $display("[TB] FAIL midop_stays_idle: got %b, want 0000000", {diff4, bout4, busy4, done4});
    end
  endtask

  task automatic test_negative();
    logic [3:0] ta[3] = '{4'b0111, 4'b0000, 4'b1001};
    logic [3:0] tb[3] = '{4'b1010, 4'b0001, 4'b1001};
    logic [3:0] wantD[3] = '{4'b1101, 4'b1111, 4'b0000};
    logic       wantB[3] = '{1'b1, 1'b1, 1'b0};
    int edges;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      startOp4(ta[i], tb[i]);
      waitDone4(edges);
      e = q4.pop_front();
      nChecks++;
      if (edges != 4 || diff4 !== wantD[i] || bout4 !== wantB[i] || e.diff[3:0] !== wantD[i]) begin
        nFails++;
        $display("[TB] FAIL negative_%0d: got diff=%b bout=%b edges=%0d, want diff=%b bout=%b edges=4",
                 i, diff4, bout4, edges, wantD[i], wantB[i]);
      end
      heldDiff4 = diff4;
    end
  endtask

  task automatic test_restart();
    int edges;
    exp_t e;
    startOp4(4'b1100, 4'b0011);
    void'(q4.pop_back());
    nChecks++;
    if (diff4 !== heldDiff4) begin
      nFails++;
      $display("[TB] FAIL restart_hold_first: got %b, want %b", diff4, heldDiff4);
    end
    startOp4(4'b0101, 4'b0110);
    nChecks++;
    if (diff4 !== heldDiff4 || done4 !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL restart_hold_second: got diff=%b done=%b, want diff=%b done=0", diff4, done4, heldDiff4);
    end
    waitDone4(edges);
    e = q4.pop_front();
    nChecks++;
    if (edges != 4 || diff4 !== 4'b1111 || bout4 !== 1'b1 || e.diff[3:0] !== 4'b1111) begin
      nFails++;
      $display("[TB] FAIL restart_result: got diff=%b bout=%b edges=%0d, want 1111 1 4", diff4, bout4, edges);
    end
    heldDiff4 = diff4;
  endtask

  task automatic test_load_on_completion();
    int edges;
    exp_t e;
    startOp4(4'b0110, 4'b0001);
    void'(q4.pop_back());
    repeat (2) @(negedge clk);
    // The first operation would complete at the same edge that samples this load.
    startOp4(4'b0010, 4'b1011);
    nChecks++;
    if (done4 !== 1'b0 || diff4 !== heldDiff4 || busy4 !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL loadcomp_suppress: got done=%b diff=%b busy=%b, want 0 %b 1", done4, diff4, busy4, heldDiff4);
    end
    waitDone4(edges);
    e = q4.pop_front();
    nChecks++;
    if (edges != 4 || diff4 !== e.diff[3:0] || bout4 !== e.bout || diff4 !== 4'b0111) begin
      nFails++;
      $display("[TB] FAIL loadcomp_result: got diff=%b bout=%b edges=%0d, want 0111 1 4", diff4, bout4, edges);
    end
    heldDiff4 = diff4;
  endtask

  task automatic test_back_to_back();
    int edges;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      startOp4(4'(i * 5 + 3), 4'(i * 3 + 6));
      waitDone4(edges);
      e = q4.pop_front();
      nChecks++;
      if (edges != 4 || diff4 !== e.diff[3:0] || bout4 !== e.bout) begin
        nFails++;
        $display("[TB] FAIL back_to_back_%0d: got diff=%b bout=%b edges=%0d, want %b %b 4",
                 i, diff4, bout4, edges, e.diff[3:0], e.bout);
      end
    end
  endtask

  task automatic test_exhaustive();
    int edges;
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      startOp4(4'(i >> 4), 4'(i));
      waitDone4(edges);
      e = q4.pop_front();
      nChecks++;
      if (edges != 4 || diff4 !== e.diff[3:0] || bout4 !== e.bout) begin
        nFails++;
        $display("[TB] FAIL exhaustive a=%0d b=%0d: got diff=%0d bout=%b edges=%0d, want %0d %b 4",
                 i >> 4, i & 15, diff4, bout4, edges, e.diff[3:0], e.bout);
      end
    end
  endtask

  // An adder model feeds its sum back into the subtractor. The sum minus b
  // must return a, and the borrow must equal the adder's carry-out.
  task automatic test_round_trip();
    int edges;
    exp_t e;
    logic [4:0] sum;
    for (int i = 0; i < 256; i++) begin
      sum = 5'(i >> 4) + 5'(i & 15);
      startOp4(sum[3:0], 4'(i));
      e = q4.pop_back();
      e.diff = 8'(i >> 4);
      e.bout = sum[4];
      q4.push_back(e);
      waitDone4(edges);
      e = q4.pop_front();
      nChecks++;
      if (edges != 4 || diff4 !== e.diff[3:0] || bout4 !== e.bout) begin
        nFails++;
        $display("[TB] FAIL round_trip a=%0d b=%0d: got diff=%0d bout=%b, want %0d %b",
                 i >> 4, i & 15, diff4, bout4, e.diff[3:0], e.bout);
      end
    end
  endtask

  task automatic test_random8();
    int edges;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      startOp8(8'($urandom_range(255)), 8'($urandom_range(255)));
      waitDone8(edges);
      e = q8.pop_front();
      nChecks++;
      if (edges != 8 || diff8 !== e.diff || bout8 !== e.bout || busy8 !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL random8_%0d a=%0d b=%0d: got diff=%0d bout=%b edges=%0d, want %0d %b 8",
                 i, a8, b8, diff8, bout8, edges, e.diff, e.bout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_midop();
    test_negative();
    test_restart();
    test_load_on_completion();
    test_back_to_back();
    test_exhaustive();
    test_round_trip();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
